// File: rtl/lut3d_pkg.sv
// Shared types and helpers for the 3D-LUT configuration path.
package lut3d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } lut3d_ld_state_e;

    // Component slots inside one packed entry, shared with color_mapping_3dlut.
    localparam int R_IDX = 0;
    localparam int G_IDX = 1;
    localparam int B_IDX = 2;

    // Bytes needed to carry one LUT component.
    function automatic int lut3d_bpc(input int lut_cd);
        return (lut_cd + 7) / 8;
    endfunction

    // Number of grid entries in a cube of gs points per axis.
    function automatic int lut3d_nent(input int gs);
        return gs * gs * gs;
    endfunction

endpackage

// File: rtl/lut3d_cfg_loader_if.sv
// Host byte stream in, mapper configuration write port and status out.
interface lut3d_cfg_loader_if
    import lut3d_pkg::*;
#(
    parameter int GS     = 33,
    parameter int LUT_CD = 10
);
    localparam int NENT = lut3d_nent(GS);
    localparam int CW   = $clog2(NENT);

    logic                  i_start;
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  o_byte_ready;
    logic [3*LUT_CD-1:0]   o_cfg_data;
    logic                  o_cfg_valid;
    logic                  o_cfg_last;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;
    logic [CW-1:0]         o_entry_cnt;

    modport master (
        output i_start, i_byte, i_byte_valid,
        input  o_byte_ready, o_cfg_data, o_cfg_valid, o_cfg_last,
        input  o_busy, o_done, o_err, o_entry_cnt
    );

    modport slave (
        input  i_start, i_byte, i_byte_valid,
        output o_byte_ready, o_cfg_data, o_cfg_valid, o_cfg_last,
        output o_busy, o_done, o_err, o_entry_cnt
    );

endinterface

// File: rtl/lut3d_entry_pack.sv
// Collects little-endian component bytes (R, G, B) into one packed LUT entry.
// Bits above LUT_CD in each component are dropped.
module lut3d_entry_pack
    import lut3d_pkg::*;
#(
    parameter int LUT_CD = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                byte_en,
    input  logic [7:0]          byte_in,
    output logic [3*LUT_CD-1:0] entry_data,
    output logic                entry_done
);
    localparam int BPC = lut3d_bpc(LUT_CD);
    localparam int BPE = 3 * BPC;
    localparam int BCW = $clog2(BPE);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPE - 1);

    logic [BCW-1:0]       byte_cnt;
    logic [(BPE-1)*8-1:0] part;
    logic [BPE*8-1:0]     raw;
    logic                 unused_bits;

    // The final byte is taken straight from the input so the entry is ready in the handshake cycle.
    assign raw         = {byte_in, part};
    assign entry_done  = byte_en && (byte_cnt == LAST_BYTE);
    assign unused_bits = ^raw;

    assign entry_data[R_IDX*LUT_CD +: LUT_CD] = raw[R_IDX*BPC*8 +: LUT_CD];
    assign entry_data[G_IDX*LUT_CD +: LUT_CD] = raw[G_IDX*BPC*8 +: LUT_CD];
    assign entry_data[B_IDX*LUT_CD +: LUT_CD] = raw[B_IDX*BPC*8 +: LUT_CD];

    // Byte position counter and storage for the bytes preceding the final one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
            part     <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            part     <= '0;
        end else if (byte_en) begin
            if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
            end else begin
                part[int'(byte_cnt)*8 +: 8] <= byte_in;
                byte_cnt                    <= byte_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: rtl/lut3d_cfg_loader.sv
// Load sequencer for the 3D-LUT mapper: turns the host byte stream into entry
// writes and, on an aborted load, pads the sweep with zero entries so the
// downstream write address always wraps cleanly.
module lut3d_cfg_loader
    import lut3d_pkg::*;
#(
    parameter int GS     = 33,
    parameter int LUT_CD = 10
) (
    input  logic              clk,
    input  logic              rstn,
    lut3d_cfg_loader_if.slave bus
);
    localparam int NENT = lut3d_nent(GS);
    localparam int CW   = $clog2(NENT);
    localparam int DW   = 3 * LUT_CD;
    localparam logic [CW-1:0] LAST_ENT = CW'(NENT - 1);

    lut3d_ld_state_e state, state_nxt;

    logic [DW-1:0] cfg_data_q, cfg_data_nxt;
    logic          cfg_valid_q, cfg_valid_nxt;
    logic          cfg_last_q, cfg_last_nxt;
    logic          done_q, done_nxt;
    logic          err_q, err_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;

    logic          byte_ready;
    logic          accept;
    logic          pack_en;
    logic          pack_clr;
    logic [DW-1:0] entry_data;
    logic          entry_done;

    assign byte_ready = (state != FLUSH);
    assign accept     = bus.i_byte_valid && byte_ready;
    // A start always wins over a coinciding byte and discards any partial entry.
    assign pack_en    = (state == LOAD) && !bus.i_start && accept;
    assign pack_clr   = bus.i_start && (state != FLUSH);

    lut3d_entry_pack #(.LUT_CD(LUT_CD)) u_pack (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (pack_clr),
        .byte_en    (pack_en),
        .byte_in    (bus.i_byte),
        .entry_data (entry_data),
        .entry_done (entry_done)
    );

    // State and registered write port / status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cfg_data_q  <= '0;
            cfg_valid_q <= 1'b0;
            cfg_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state       <= state_nxt;
            cfg_data_q  <= cfg_data_nxt;
            cfg_valid_q <= cfg_valid_nxt;
            cfg_last_q  <= cfg_last_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
            cnt_q       <= cnt_nxt;
        end
    end

    // Next-state, write generation and sticky flag updates.
    always_comb begin
        state_nxt     = state;
        cfg_data_nxt  = cfg_data_q;
        cfg_valid_nxt = 1'b0;
        cfg_last_nxt  = 1'b0;
        done_nxt      = done_q;
        err_nxt       = err_q;
        cnt_nxt       = cnt_q;
        case (state)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_nxt = LOAD;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end else if (accept) begin
                    err_nxt = 1'b1;
                end
            end
            LOAD: begin
                if (bus.i_start) begin
                    if (cnt_q != '0) begin
                        state_nxt = FLUSH;
                        err_nxt   = 1'b1;
                    end
                end else if (entry_done) begin
                    cfg_valid_nxt = 1'b1;
                    cfg_data_nxt  = entry_data;
                    if (cnt_q == LAST_ENT) begin
                        cfg_last_nxt = 1'b1;
                        done_nxt     = 1'b1;
                        cnt_nxt      = '0;
                        state_nxt    = DONE;
                    end else begin
                        cnt_nxt = cnt_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                cfg_valid_nxt = 1'b1;
                cfg_data_nxt  = '0;
                if (cnt_q == LAST_ENT) begin
                    cfg_last_nxt = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = LOAD;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_byte_ready = byte_ready;
    assign bus.o_cfg_data   = cfg_data_q;
    assign bus.o_cfg_valid  = cfg_valid_q;
    assign bus.o_cfg_last   = cfg_last_q;
    assign bus.o_busy       = (state == LOAD) || (state == FLUSH);
    assign bus.o_done       = done_q;
    assign bus.o_err        = err_q;
    assign bus.o_entry_cnt  = cnt_q;

endmodule

// File: tb/tb_lut3d_cfg_loader.sv
// Randomised and directed bench for lut3d_cfg_loader, checked cycle by cycle
// against a byte-queue reference model.
module tb_lut3d_cfg_loader;
    import lut3d_pkg::*;

    localparam int GS     = 3;
    localparam int LUT_CD = 10;
    localparam int NENT   = GS * GS * GS;
    localparam int BPC    = (LUT_CD + 7) / 8;
    localparam int BPE    = 3 * BPC;
    localparam int DW     = 3 * LUT_CD;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    lut3d_cfg_loader_if #(.GS(GS), .LUT_CD(LUT_CD)) bus ();

    lut3d_cfg_loader #(.GS(GS), .LUT_CD(LUT_CD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference model: whole-load view kept as a byte queue plus counters.
    bit            m_active;
    int            m_flush_left;
    int            m_entries;
    bit            m_done;
    bit            m_err;
    bit            m_valid;
    bit            m_last;
    logic [DW-1:0] m_data;
    logic [7:0]    m_bytes[$];

    int n_checks = 0;
    int n_errors = 0;
    int obs_writes = 0;
    int obs_lasts = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_active     = 1'b0;
        m_flush_left = 0;
        m_entries    = 0;
        m_done       = 1'b0;
        m_err        = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        m_data       = '0;
        m_bytes.delete();
    endtask

    // Advance the model by one clock with the inputs the DUT will sample.
    task automatic modelStep(input bit start, input bit valid, input logic [7:0] b);
        longint word;
        longint comp;
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (m_flush_left > 0) begin
            m_valid = 1'b1;
            m_data  = '0;
            m_entries++;
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_last    = 1'b1;
                m_entries = 0;
            end
        end else if (!m_active) begin
            if (start) begin
                m_active  = 1'b1;
                m_done    = 1'b0;
                m_err     = 1'b0;
                m_entries = 0;
                m_bytes.delete();
            end else if (valid) begin
                m_err = 1'b1;
            end
        end else if (start) begin
            m_bytes.delete();
            if (m_entries != 0) begin
                m_err        = 1'b1;
                m_flush_left = NENT - m_entries;
            end
        end else if (valid) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == BPE) begin
                word = 0;
                for (int c = 0; c < 3; c++) begin
                    comp = 0;
                    for (int k = 0; k < BPC; k++)
                        comp = comp + (longint'(m_bytes[c*BPC+k]) << (8*k));
                    comp = comp % (longint'(1) << LUT_CD);
                    word = word + (comp << (c*LUT_CD));
                end
                m_data  = DW'(word);
                m_valid = 1'b1;
                m_entries++;
                m_bytes.delete();
                if (m_entries == NENT) begin
                    m_last    = 1'b1;
                    m_done    = 1'b1;
                    m_active  = 1'b0;
                    m_entries = 0;
                end
            end
        end
    endtask

    task automatic checkAll(input string ctx);
        checkOutput({ctx, ".valid"}, 64'(bus.o_cfg_valid), 64'(m_valid));
        checkOutput({ctx, ".last"},  64'(bus.o_cfg_last),  64'(m_last));
        checkOutput({ctx, ".data"},  64'(bus.o_cfg_data),  64'(m_data));
        checkOutput({ctx, ".done"},  64'(bus.o_done),      64'(m_done));
        checkOutput({ctx, ".err"},   64'(bus.o_err),       64'(m_err));
        checkOutput({ctx, ".busy"},  64'(bus.o_busy),      64'(m_active));
        checkOutput({ctx, ".ready"}, 64'(bus.o_byte_ready), 64'(m_flush_left == 0));
        checkOutput({ctx, ".cnt"},   64'(bus.o_entry_cnt), 64'(m_entries));
    endtask

    // Drive one cycle of inputs on the falling edge and compare just after the rising edge.
    task automatic applyStimulus(input bit start, input bit valid, input logic [7:0] b);
        @(negedge clk);
        bus.i_start      = start;
        bus.i_byte_valid = valid;
        bus.i_byte       = b;
        modelStep(start, valid, b);
        @(posedge clk);
        #1;
        checkAll("cyc");
        if (bus.o_cfg_valid === 1'b1) obs_writes++;
        if (bus.o_cfg_last === 1'b1) obs_lasts++;
    endtask

    task automatic sendBytes(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    endtask

    // Start a load and let any padding sweep it triggers run out.
    task automatic startLoad();
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < NENT + 2 && m_flush_left > 0; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] pat_a[6] = '{8'h34, 8'h12, 8'hFF, 8'h03, 8'h00, 8'h00};
    logic [7:0] pat_b[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    initial begin
        bus.i_start      = 1'b0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'h00;
        modelReset();
        #3;
        checkAll("reset");
        checkOutput("reset.ready_one", 64'(bus.o_byte_ready), 64'd1);
        #9 rstn = 1'b1;

        // Scenario 1: first entry from a known pattern.
        $display("[TB] first entry");
        applyStimulus(1'b1, 1'b0, 8'h00);
        obs_writes = 0;
        obs_lasts  = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, pat_a[i]);
        checkOutput("s1.valid", 64'(bus.o_cfg_valid), 64'd1);
        checkOutput("s1.data", 64'(bus.o_cfg_data), 64'h00FFE34);

        // Scenario 2: the rest of the sweep streamed back to back.
        $display("[TB] full load");
        sendBytes(NENT * BPE - 6);
        checkOutput("s2.writes", 64'(obs_writes), 64'(NENT));
        checkOutput("s2.lasts", 64'(obs_lasts), 64'd1);
        checkOutput("s2.done", 64'(bus.o_done), 64'd1);
        checkOutput("s2.busy", 64'(bus.o_busy), 64'd0);
        checkOutput("s2.cnt", 64'(bus.o_entry_cnt), 64'd0);

        // Scenario 5: stray byte after completion, then a start clears the error.
        $display("[TB] stray byte");
        obs_writes = 0;
        applyStimulus(1'b0, 1'b1, 8'h77);
        checkOutput("s5.err", 64'(bus.o_err), 64'd1);
        checkOutput("s5.nowrite", 64'(obs_writes), 64'd0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("s5.err_clr", 64'(bus.o_err), 64'd0);

        // Scenario 3: abort after 10 entries, padding sweep, then a clean full load.
        $display("[TB] abort and flush");
        sendBytes(10 * BPE);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("s3.err", 64'(bus.o_err), 64'd1);
        checkOutput("s3.ready0", 64'(bus.o_byte_ready), 64'd0);
        obs_writes = 0;
        obs_lasts  = 0;
        for (int i = 0; i < NENT - 10; i++) begin
            applyStimulus(1'b0, 1'b1, 8'($urandom));
            if (i < NENT - 11) checkOutput("s3.ready_flush", 64'(bus.o_byte_ready), 64'd0);
        end
        checkOutput("s3.flush_writes", 64'(obs_writes), 64'(NENT - 10));
        checkOutput("s3.flush_last", 64'(bus.o_cfg_last), 64'd1);
        checkOutput("s3.busy_load", 64'(bus.o_busy), 64'd1);
        obs_lasts = 0;
        sendBytes(NENT * BPE);
        checkOutput("s3.reload_last", 64'(obs_lasts), 64'd1);
        checkOutput("s3.err_sticky", 64'(bus.o_err), 64'd1);
        checkOutput("s3.done", 64'(bus.o_done), 64'd1);

        // Scenario 4: restart in place with no entry emitted yet.
        $display("[TB] restart in place");
        applyStimulus(1'b1, 1'b0, 8'h00);
        obs_writes = 0;
        sendBytes(3);
        applyStimulus(1'b1, 1'b1, 8'hEE);
        checkOutput("s4.nowrite", 64'(obs_writes), 64'd0);
        checkOutput("s4.err", 64'(bus.o_err), 64'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, pat_b[i]);
        checkOutput("s4.data", 64'(bus.o_cfg_data), 64'h2550CE11);
        checkOutput("s4.writes", 64'(obs_writes), 64'd1);

        // Scenario 6: asynchronous reset in the middle of an entry.
        $display("[TB] mid-entry reset");
        sendBytes(3 * BPE + 2);
        @(negedge clk);
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = 8'h5A;
        #2 rstn = 1'b0;
        #1;
        modelReset();
        checkAll("s6.rst");
        checkOutput("s6.cnt0", 64'(bus.o_entry_cnt), 64'd0);
        bus.i_byte_valid = 1'b0;
        #1 rstn = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, pat_a[i]);
        checkOutput("s6.data", 64'(bus.o_cfg_data), 64'h00FFE34);
        checkOutput("s6.cnt1", 64'(bus.o_entry_cnt), 64'd1);

        // Start coinciding with the final byte of the final entry.
        $display("[TB] start on final byte");
        startLoad();
        sendBytes(NENT * BPE - 1);
        applyStimulus(1'b1, 1'b1, 8'hAA);
        checkOutput("edge.err", 64'(bus.o_err), 64'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("edge.valid", 64'(bus.o_cfg_valid), 64'd1);
        checkOutput("edge.last", 64'(bus.o_cfg_last), 64'd1);
        checkOutput("edge.data", 64'(bus.o_cfg_data), 64'd0);

        // Random traffic with occasional starts.
        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++)
            applyStimulus($urandom_range(0, 249) == 0, $urandom_range(0, 9) < 8, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lut3d_cfg_loader.md
Name: lut3d_cfg_loader

Overview:
Upstream configuration stage for the 3D-LUT colour mapper. It takes a byte stream from the host side (UART/SPI/DMA bridge) and assembles R/G/B grid entries. It emits one LUT_CD*3-bit write per entry on the mapper's cfg_data/cfg_valid/cfg_last interface, and asserts cfg_last on entry GS^3-1. It also guarantees the downstream RAM write address always completes a full GS^3 sweep, including when a load is aborted.

Parameters:
GS, 33, grid size per axis (17, 33 or 65); the LUT holds GS^3 entries.
LUT_CD, 10, bits per LUT component (8..16).
(derived) BPC = (LUT_CD+7)/8, bytes per component.
(derived) BPE = 3*BPC, bytes per entry.
(derived) NENT = GS^3.
(derived) CW = $clog2(NENT).

Ports:
clk  in  1  single clock, the pixel-domain clock of the mapper.
rstn  in  1  asynchronous active-low reset.
i_start  in  1  one-cycle pulse that begins a new LUT load.
i_byte  in  8  configuration byte.
i_byte_valid  in  1  byte valid.
o_byte_ready  out  1  byte accepted when valid && ready.
o_cfg_data  out  LUT_CD*3  entry: R in [LUT_CD-1:0], G in [2*LUT_CD-1:LUT_CD], B in top.
o_cfg_valid  out  1  one-cycle write strobe; no backpressure.
o_cfg_last  out  1  high with o_cfg_valid on entry NENT-1 only.
o_busy  out  1  state is LOAD or FLUSH.
o_done  out  1  sticky; a full LUT was loaded without abort.
o_err  out  1  sticky; protocol error.
o_entry_cnt  out  CW  entries emitted in the current sweep.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rstn.
- Reset state: IDLE. All outputs are 0 except o_byte_ready=1. Counters and the partial-entry register are cleared.
- States:
  - IDLE: ready=1. Bytes are drained; any accepted byte sets o_err.
  - LOAD: ready=1.
  - FLUSH: ready=0.
  - DONE: ready=1. Behaves like IDLE for stray bytes (drain, set o_err).
- Transitions:
  - IDLE/DONE + i_start -> LOAD. Clears o_done, o_err, the byte counter and the entry counter.
  - LOAD + last byte of entry NENT-1 -> DONE; o_done=1 in the same cycle as o_cfg_last.
  - LOAD + i_start:
    - If entry_cnt==0, restart in place: drop the partial entry; o_err unaffected.
    - Otherwise go to FLUSH and set o_err.
  - FLUSH: emits one all-zero entry per cycle from entry_cnt through NENT-1, with o_cfg_last on the final one. Then -> LOAD with counters at 0. i_start during FLUSH is ignored.
- Byte assembly:
  - Component order within an entry: R, G, B.
  - Each component is BPC bytes, little-endian.
  - Bits above LUT_CD are discarded silently; no error.
  - The byte counter runs 0..BPE-1 and wraps.
- Latency: o_cfg_valid is registered and asserts exactly 1 cycle after the handshake of the entry's final byte. o_cfg_data holds until the next write. Back-to-back bytes on every cycle give one write per BPE cycles.
- i_start coincident with a byte handshake: i_start wins and the byte is dropped. In LOAD with entry_cnt==0, the byte is not counted.
- i_start coincident with the final byte of entry NENT-1: the byte is dropped and the entry is not emitted. This is treated as LOAD + i_start with entry_cnt=NENT-1, so FLUSH emits one zero entry with last.
- o_entry_cnt increments on each o_cfg_valid and wraps to 0 after last.
- Reset mid-operation: state returns to IDLE immediately. The downstream RAM must be reset on the same rstn.

Decomposition:
- Package lut3d_pkg:
  - typedef enum {IDLE, LOAD, FLUSH, DONE} lut3d_ld_state_e.
  - Functions lut3d_bpc(LUT_CD) and lut3d_nent(GS).
  - Component-order localparams R_IDX=0, G_IDX=1, B_IDX=2, shared with color_mapping_3dlut.
- One sub-module, lut3d_entry_pack: byte counter plus shift/truncate into the LUT_CD*3 entry; asserts entry_done on the final byte. The FSM, flush generation and status flags stay in the top.

Test Plan:
All scenarios use GS=3 (NENT=27), LUT_CD=10 (BPE=6).
1. Reset -> o_byte_ready=1, all other outputs 0. Start, then bytes 34 12 FF 03 00 00 -> one cycle after the 6th byte, o_cfg_valid=1 and o_cfg_data=0x00FFE34 (R=0x234, G=0x3FF, B=0).
2. Start, then 162 bytes streamed on consecutive cycles -> 27 writes spaced 6 cycles apart; o_cfg_last only on the 27th; o_done=1, o_busy=0; o_entry_cnt returns to 0.
3. Start, 10 entries, then i_start -> o_err=1; 17 consecutive zero writes with last on the 17th; o_byte_ready=0 throughout; then LOAD. A full 162-byte load afterwards ends with last after 27 writes; o_err stays 1 until the next start from DONE.
4. Start, 3 bytes, i_start (entry_cnt=0) -> no writes, no o_err; the next 6 bytes form entry 0 correctly.
5. After DONE, one stray byte -> accepted, o_err=1, no write. Start -> o_err cleared.
6. Assert rstn low mid-entry 5 with a byte valid -> outputs return to reset values asynchronously. After release plus start, entry 0 is assembled from fresh bytes.
